// File: rtl/clock_pkg.sv
// ============================================================================
// clock_pkg : shared state encoding and BCD constants for the 12-hour clock
// Revision  : 1.0
// ============================================================================
`default_nettype none

package clock_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2
   } clk_state_t;

   localparam logic [7:0] HR_RESET   = 8'h12;
   localparam logic [7:0] HR_MAX     = 8'h12;
   localparam logic [7:0] HR_PM_EDGE = 8'h11;
   localparam logic [7:0] MS_MAX     = 8'h59;
   localparam logic [7:0] BCD_ZERO   = 8'h00;

endpackage

`default_nettype wire

// File: rtl/btn_rise.sv
// ============================================================================
// btn_rise : registered-history rising-edge detector, one pulse per press
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_rise (
   input  logic clk,
   input  logic reset,
   input  logic lvl,
   output logic pulse
);

   logic r_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= lvl;
      end
   end

   // Pulse is taken straight from the live level so the press acts on this edge.
   assign pulse = lvl & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/clock_time_ctrl.sv
// ============================================================================
// clock_time_ctrl : 12-hour BCD time keeper with two-button time setting.
// Optional macro CLOCK_SET_SEC_CLEAR_EN clears seconds when leaving SET_MIN.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module clock_time_ctrl
   import clock_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       mode_btn,
   input  logic       inc_btn,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic       pm,
   output logic       set_hr,
   output logic       set_min
);

   function automatic logic [7:0] ms_inc(input logic [7:0] v);
      logic [3:0] t;
      logic [3:0] u;
      t = v[7:4];
      u = v[3:0];
      if (v == MS_MAX) begin
         return BCD_ZERO;
      end else if (u == 4'd9) begin
         return {t + 4'd1, 4'd0};
      end else begin
         return {t, u + 4'd1};
      end
   endfunction

   function automatic logic [7:0] hr_inc(input logic [7:0] v);
      logic [3:0] t;
      logic [3:0] u;
      t = v[7:4];
      u = v[3:0];
      if (v == HR_MAX) begin
         return 8'h01;
      end else if (u == 4'd9) begin
         return {t + 4'd1, 4'd0};
      end else begin
         return {t, u + 4'd1};
      end
   endfunction

   clk_state_t r_state;
   clk_state_t w_state_nxt;
   logic [7:0] r_hh, r_mm, r_ss;
   logic [7:0] w_hh_nxt, w_mm_nxt, w_ss_nxt;
   logic       r_pm, w_pm_nxt;
   logic       r_set_hr, r_set_min;
   logic       w_mode_p, w_inc_p, w_inc_ok;

   btn_rise u_mode_rise (
      .clk   (clk),
      .reset (reset),
      .lvl   (mode_btn),
      .pulse (w_mode_p)
   );

   btn_rise u_inc_rise (
      .clk   (clk),
      .reset (reset),
      .lvl   (inc_btn),
      .pulse (w_inc_p)
   );

   // A mode press in the same cycle swallows the increment.
   assign w_inc_ok = w_inc_p & ~w_mode_p;

   always_comb begin
      w_state_nxt = r_state;
      w_hh_nxt    = r_hh;
      w_mm_nxt    = r_mm;
      w_ss_nxt    = r_ss;
      w_pm_nxt    = r_pm;
      case (r_state)
         RUN: begin
            if (w_mode_p) begin
               w_state_nxt = SET_HR;
            end
            if (tick) begin
               w_ss_nxt = ms_inc(r_ss);
               if (r_ss == MS_MAX) begin
                  w_mm_nxt = ms_inc(r_mm);
                  if (r_mm == MS_MAX) begin
                     w_hh_nxt = hr_inc(r_hh);
                     if (r_hh == HR_PM_EDGE) begin
                        w_pm_nxt = ~r_pm;
                     end
                  end
               end
            end
         end
         SET_HR: begin
            if (w_mode_p) begin
               w_state_nxt = SET_MIN;
            end else if (w_inc_ok) begin
               w_hh_nxt = hr_inc(r_hh);
               if (r_hh == HR_PM_EDGE) begin
                  w_pm_nxt = ~r_pm;
               end
            end
         end
         SET_MIN: begin
            if (w_mode_p) begin
               w_state_nxt = RUN;
`ifdef CLOCK_SET_SEC_CLEAR_EN
               w_ss_nxt = BCD_ZERO;
`endif
            end else if (w_inc_ok) begin
               w_mm_nxt = ms_inc(r_mm);
            end
         end
         default: begin
            w_state_nxt = RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= RUN;
         r_hh      <= HR_RESET;
         r_mm      <= BCD_ZERO;
         r_ss      <= BCD_ZERO;
         r_pm      <= 1'b0;
         r_set_hr  <= 1'b0;
         r_set_min <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_hh      <= w_hh_nxt;
         r_mm      <= w_mm_nxt;
         r_ss      <= w_ss_nxt;
         r_pm      <= w_pm_nxt;
         r_set_hr  <= (w_state_nxt == SET_HR);
         r_set_min <= (w_state_nxt == SET_MIN);
      end
   end

   assign hh      = r_hh;
   assign mm      = r_mm;
   assign ss      = r_ss;
   assign pm      = r_pm;
   assign set_hr  = r_set_hr;
   assign set_min = r_set_min;

endmodule

`default_nettype wire

// File: tb/tb_clock_time_ctrl.sv
// ============================================================================
// tb_clock_time_ctrl : directed self-checking bench for clock_time_ctrl
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_clock_time_ctrl;

   logic       clk;
   logic       reset;
   logic       tick;
   logic       mode_btn;
   logic       inc_btn;
   logic [7:0] hh, mm, ss;
   logic       pm, set_hr, set_min;

   int checks;
   int failures;

   clock_time_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .mode_btn (mode_btn),
      .inc_btn  (inc_btn),
      .hh       (hh),
      .mm       (mm),
      .ss       (ss),
      .pm       (pm),
      .set_hr   (set_hr),
      .set_min  (set_min)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled on a later falling edge.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic press_mode(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); mode_btn = 1'b1;
         @(negedge clk); mode_btn = 1'b0;
      end
   endtask

   task automatic press_inc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); inc_btn = 1'b1;
         @(negedge clk); inc_btn = 1'b0;
      end
   endtask

   task automatic run_ticks(input int n);
      @(negedge clk); tick = 1'b1;
      repeat (n) @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      repeat (5) @(negedge clk);
      checks++;
      if ({hh, mm, ss} !== 24'h120000) begin
         failures++;
         $display("FAIL reset_time: got %h:%h:%h want 12:00:00", hh, mm, ss);
      end
      checks++;
      if ({pm, set_hr, set_min} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags: got pm/hr/min=%b%b%b want 000", pm, set_hr, set_min);
      end
   endtask

   task automatic test_rollover();
      do_reset();
      press_mode(1);
      press_inc(11);
      press_mode(1);
      press_inc(59);
      press_mode(1);
      checks++;
      if ({hh, mm, ss, pm, set_hr, set_min} !== {24'h115900, 3'b000}) begin
         failures++;
         $display("FAIL set_1159: got %h:%h:%h pm=%b hr=%b min=%b want 11:59:00 AM RUN",
                  hh, mm, ss, pm, set_hr, set_min);
      end
      press_inc(3);
      checks++;
      if (hh !== 8'h11 || mm !== 8'h59) begin
         failures++;
         $display("FAIL run_inc_ignored: got %h:%h want 11:59", hh, mm);
      end
      run_ticks(59);
      checks++;
      if ({hh, mm, ss, pm} !== {24'h115959, 1'b0}) begin
         failures++;
         $display("FAIL pre_noon: got %h:%h:%h pm=%b want 11:59:59 AM", hh, mm, ss, pm);
      end
      run_ticks(1);
      checks++;
      if ({hh, mm, ss, pm} !== {24'h120000, 1'b1}) begin
         failures++;
         $display("FAIL noon: got %h:%h:%h pm=%b want 12:00:00 PM", hh, mm, ss, pm);
      end
      run_ticks(3600);
      checks++;
      if ({hh, mm, ss, pm} !== {24'h010000, 1'b1}) begin
         failures++;
         $display("FAIL one_pm: got %h:%h:%h pm=%b want 01:00:00 PM", hh, mm, ss, pm);
      end
   endtask

   task automatic test_set_fields();
      do_reset();
      press_mode(1);
      press_inc(3);
      checks++;
      if (set_hr !== 1'b1 || hh !== 8'h03 || pm !== 1'b0) begin
         failures++;
         $display("FAIL set_hr_03: got set_hr=%b hh=%h pm=%b want 1 03 0", set_hr, hh, pm);
      end
      press_mode(1);
      press_inc(60);
      checks++;
      if (set_min !== 1'b1 || set_hr !== 1'b0 || mm !== 8'h00 || hh !== 8'h03) begin
         failures++;
         $display("FAIL set_min_wrap: got min=%b hr=%b mm=%h hh=%h want 1 0 00 03",
                  set_min, set_hr, mm, hh);
      end
      press_inc(10);
      checks++;
      if (mm !== 8'h10) begin
         failures++;
         $display("FAIL set_min_bcd: got mm=%h want 10", mm);
      end
   endtask

   task automatic test_set_hr_holds();
      do_reset();
      run_ticks(5);
      press_mode(1);
      run_ticks(10);
      checks++;
      if (ss !== 8'h05 || mm !== 8'h00 || set_hr !== 1'b1) begin
         failures++;
         $display("FAIL set_hr_tick_ignored: got ss=%h mm=%h set_hr=%b want 05 00 1", ss, mm, set_hr);
      end
      @(negedge clk); inc_btn = 1'b1;
      repeat (20) @(negedge clk);
      inc_btn = 1'b0;
      @(negedge clk);
      checks++;
      if (hh !== 8'h01 || pm !== 1'b0) begin
         failures++;
         $display("FAIL held_inc: got hh=%h pm=%b want 01 0", hh, pm);
      end
      @(negedge clk); mode_btn = 1'b1; inc_btn = 1'b1;
      @(negedge clk); mode_btn = 1'b0; inc_btn = 1'b0;
      checks++;
      if (set_min !== 1'b1 || set_hr !== 1'b0 || hh !== 8'h01 || mm !== 8'h00) begin
         failures++;
         $display("FAIL mode_beats_inc: got min=%b hr=%b hh=%h mm=%h want 1 0 01 00",
                  set_min, set_hr, hh, mm);
      end
      press_inc(37);
      checks++;
      if (mm !== 8'h37) begin
         failures++;
         $display("FAIL set_min_37: got mm=%h want 37", mm);
      end
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      checks++;
      if ({hh, mm, ss, pm, set_hr, set_min} !== {24'h120000, 3'b000}) begin
         failures++;
         $display("FAIL reset_mid_set: got %h:%h:%h pm=%b hr=%b min=%b want 12:00:00 000",
                  hh, mm, ss, pm, set_hr, set_min);
      end
   endtask

   task automatic test_hour_edges();
      // 11 -> 12 through the set path flips pm; 12 -> 01 leaves it.
      do_reset();
      press_mode(1);
      press_inc(9);
      checks++;
      if (hh !== 8'h09) begin
         failures++;
         $display("FAIL hr_09: got hh=%h want 09", hh);
      end
      press_inc(1);
      checks++;
      if (hh !== 8'h10) begin
         failures++;
         $display("FAIL hr_10: got hh=%h want 10", hh);
      end
      press_inc(2);
      checks++;
      if (hh !== 8'h12 || pm !== 1'b1) begin
         failures++;
         $display("FAIL hr_set_noon: got hh=%h pm=%b want 12 1", hh, pm);
      end
      press_inc(1);
      checks++;
      if (hh !== 8'h01 || pm !== 1'b1) begin
         failures++;
         $display("FAIL hr_set_one: got hh=%h pm=%b want 01 1", hh, pm);
      end
   endtask

   task automatic test_tick_with_mode();
      do_reset();
      @(negedge clk); tick = 1'b1; mode_btn = 1'b1;
      @(negedge clk); tick = 1'b0; mode_btn = 1'b0;
      checks++;
      if (ss !== 8'h01 || set_hr !== 1'b1) begin
         failures++;
         $display("FAIL tick_and_mode: got ss=%h set_hr=%b want 01 1", ss, set_hr);
      end
   endtask

   task automatic test_sec_clear();
      logic [7:0] exp_ss;
`ifdef CLOCK_SET_SEC_CLEAR_EN
      exp_ss = 8'h00;
`else
      exp_ss = 8'h42;
`endif
      do_reset();
      run_ticks(42);
      press_mode(2);
      checks++;
      if (ss !== 8'h42 || set_min !== 1'b1) begin
         failures++;
         $display("FAIL ss_frozen_42: got ss=%h set_min=%b want 42 1", ss, set_min);
      end
      press_mode(1);
      checks++;
      if (ss !== exp_ss || set_min !== 1'b0 || set_hr !== 1'b0) begin
         failures++;
         $display("FAIL ss_on_exit: got ss=%h min=%b hr=%b want %h 0 0", ss, set_min, set_hr, exp_ss);
      end
      run_ticks(1);
      checks++;
      if (ss !== ((exp_ss == 8'h00) ? 8'h01 : 8'h43)) begin
         failures++;
         $display("FAIL ss_resume: got ss=%h", ss);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      tick     = 1'b0;
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
      test_reset();
      test_rollover();
      test_set_fields();
      test_set_hr_holds();
      test_hour_edges();
      test_tick_with_mode();
      test_sec_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

Time-keeping controller for the 12-hour clock. It owns the hours, minutes and seconds BCD registers and the AM/PM flag. It advances them from a 1 Hz enable in run mode and sequences a two-button set-time mode (select field, increment field). It sits between the debounced/synchronized button front end and the display driver.

## Interface

Parameters:
- none (all constants come from the shared package)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk
- tick  in  1  one-cycle 1 Hz enable, synchronous to clk
- mode_btn  in  1  level, already synchronized and debounced; rising edge cycles the mode
- inc_btn  in  1  level, already synchronized and debounced; rising edge increments the selected field
- hh  out  8  hours, BCD, range 01..12
- mm  out  8  minutes, BCD, range 00..59
- ss  out  8  seconds, BCD, range 00..59
- pm  out  1  0 = AM, 1 = PM
- set_hr  out  1  high in SET_HR state
- set_min  out  1  high in SET_MIN state

## Operation

- Reset state: FSM = RUN, hh = 8'h12, mm = 8'h00, ss = 8'h00, pm = 0, set_hr = set_min = 0, edge-detector history = 0.
- Edge detection:
  - A press is a cycle where the button is sampled 1 and its previous registered sample is 0.
  - A held button produces exactly one press.
- FSM states and transitions:
  - RUN → SET_HR on mode press.
  - SET_HR → SET_MIN on mode press.
  - SET_MIN → RUN on mode press.
- RUN behaviour:
  - On tick, ss advances by 1.
  - ss = 59 wraps to 00 and carries into mm.
  - mm = 59 with a carry wraps to 00 and carries into hh.
  - inc presses are ignored.
- Hour advance rule, used for both carry and set:
  - 11 → 12 toggles pm.
  - 12 → 01 leaves pm unchanged.
  - 09 → 10 is a BCD digit rollover.
  - Otherwise the units digit increments by 1.
- SET_HR behaviour:
  - An inc press advances hh using the hour rule, including the pm toggle.
  - tick is ignored; ss, mm and pm are frozen apart from the hour rule.
- SET_MIN behaviour:
  - An inc press advances mm by 1; 59 wraps to 00 with no carry into hh.
  - tick is ignored.
- Simultaneous events:
  - mode press and inc press in the same cycle: the mode press wins and the inc is dropped.
  - tick and mode press in the same cycle in RUN: the tick is applied and the state moves to SET_HR.
  - reset overrides everything.
- Arithmetic is per-nibble BCD. Each nibble must never take a value from A to F.

## Timing

- All outputs are registered. Updates become visible after the clk edge that samples the triggering tick or press.
- Latency from button level rising to field change is 1 clk edge. There is no extra pipeline stage.
- set_hr and set_min change on the same edge as the state.
- A reset asserted mid-set discards the edit and returns to the reset values on the next edge.

## Configuration

- Macro: CLOCK_SET_SEC_CLEAR_EN.
- Defined: the transition SET_MIN → RUN also loads ss = 8'h00 on the same edge, so the minute restarts cleanly.
- Undefined: ss keeps the value frozen at entry to SET_HR and resumes counting from it.

## Structure

- Shared package clock_pkg holds:
  - state enum clk_state_t {RUN, SET_HR, SET_MIN}
  - constants HR_RESET = 8'h12, HR_MAX = 8'h12, HR_PM_EDGE = 8'h11, MS_MAX = 8'h59, BCD_ZERO = 8'h00
- One sub-module, btn_rise: a registered rising-edge detector (ports clk, reset, lvl, pulse), instantiated twice.
- BCD increment helpers are functions inside clock_time_ctrl.

## Test plan

- Reset, then 5 idle cycles → hh=12, mm=00, ss=00, pm=0, set_hr=set_min=0.
- Set to 11:59 AM via buttons, return to RUN, apply 60 ticks → hh=12, mm=00, ss=00, pm=1. Apply 3600 more ticks → hh=01, pm=1.
- Mode press, then 3 inc presses → set_hr=1, hh=03. Mode press, then 60 inc presses → set_min=1, mm=00 wrapped, hh still 03.
- In SET_HR, apply 10 ticks → ss unchanged. Hold inc_btn high for 20 cycles → hh advances exactly once.
- mode_btn and inc_btn rise in the same cycle in SET_HR → state becomes SET_MIN, hh unchanged.
- Assert reset while in SET_MIN with mm=37 → next edge: RUN, 12:00:00, pm=0. Also check SET_MIN → RUN with ss=42: ss=00 when CLOCK_SET_SEC_CLEAR_EN is defined, 42 when it is not.
